// File: rtl/shop_port_arbiter_pkg.sv
// Shared types and constants for the shop port arbiter.
// Holds the FSM encoding, ASCII keys and default widths.
package shop_port_arbiter_pkg;

    localparam int A_W     = 56;
    localparam int U_W     = 4;
    localparam int R_W     = 72;
    localparam int OWNER_W = 2;

    localparam logic [R_W-1:0] CMD_KEY  = {40'd0, "Cmd?"};
    localparam logic [A_W-1:0] PERM_KEY = {32'd0, "Adm"};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        HOLD
    } arb_state_t;

    function automatic logic [OWNER_W-1:0] rr_next(
        input logic [OWNER_W-1:0] idx,
        input int                 n
    );
        return (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/shop_rr_arbiter.sv
// Combinational round-robin grant.
// Search starts at ptr and wraps through NUM_REQ-1 back to 0.
module shop_rr_arbiter
    import shop_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [OWNER_W-1:0] gnt_idx,
    output logic               any
);

    int k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!any && req[k]) begin
                any     = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = OWNER_W'(k);
            end
        end
    end

endmodule

// File: rtl/shop_port_arbiter.sv
// Multi-terminal arbiter in front of a single shop command port.
// One strobe in flight; multi-word sessions lock the port to the owner.
module shop_port_arbiter
    import shop_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int I_A_NUM_BITS = A_W,
    parameter int I_U_NUM_BITS = U_W,
    parameter int O_A_NUM_BITS = R_W,
    parameter int RESP_LAT     = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ-1:0]              i_req_last,
    input  logic [NUM_REQ*I_A_NUM_BITS-1:0] i_req_a,
    input  logic [NUM_REQ*I_U_NUM_BITS-1:0] i_req_u,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic                            o_rdy,
    output logic [I_U_NUM_BITS-1:0]         o_u,
    output logic [I_A_NUM_BITS-1:0]         o_a,
    input  logic [O_A_NUM_BITS-1:0]         i_shop_a,
    output logic [NUM_REQ-1:0]              o_rsp_valid,
    output logic [O_A_NUM_BITS-1:0]         o_rsp_a,
    output logic                            o_timeout,
    output logic [OWNER_W-1:0]              o_owner
);

    arb_state_t state_q, state_d;

    logic [OWNER_W-1:0]      ptr_q, owner_q, sel_idx, rr_idx;
    logic [NUM_REQ-1:0]      rr_gnt, owner_oh, ready;
    logic                    rr_any, last_q, sel_last;
    logic                    take, capture;
    logic [2:0]              lat_q;
    logic [7:0]              idle_q;
    logic [I_A_NUM_BITS-1:0] sel_a, a_q;
    logic [I_U_NUM_BITS-1:0] sel_u, u_q;
    logic [O_A_NUM_BITS-1:0] rsp_q;

    shop_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req    (i_req_valid),
        .ptr    (ptr_q),
        .gnt    (rr_gnt),
        .gnt_idx(rr_idx),
        .any    (rr_any)
    );

    assign owner_oh = NUM_REQ'(1) << owner_q;

    always_comb begin
        sel_a    = '0;
        sel_u    = '0;
        sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_idx == OWNER_W'(k)) begin
                sel_a    = i_req_a[k*I_A_NUM_BITS +: I_A_NUM_BITS];
                sel_u    = i_req_u[k*I_U_NUM_BITS +: I_U_NUM_BITS];
                sel_last = i_req_last[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        sel_idx     = owner_q;
        take        = 1'b0;
        ready       = '0;
        capture     = 1'b0;
        o_rdy       = 1'b0;
        o_rsp_valid = '0;
        o_timeout   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rr_any) begin
                    sel_idx = rr_idx;
                    take    = 1'b1;
                    ready   = rr_gnt;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                o_rdy   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == 3'(RESP_LAT)) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                o_rsp_valid = owner_oh;
                state_d     = last_q ? IDLE : HOLD;
            end
            HOLD: begin
                if ((i_req_valid & owner_oh) != '0) begin
                    take    = 1'b1;
                    ready   = owner_oh;
                    state_d = ISSUE;
                end else if (idle_q == 8'(TIMEOUT - 1)) begin
                    o_timeout = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is combinational on valid, so keep it quiet while in reset.
    assign o_req_ready = i_reset_n ? ready : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr_q   <= '0;
            owner_q <= '0;
            last_q  <= 1'b0;
            a_q     <= '0;
            u_q     <= '0;
            lat_q   <= '0;
            idle_q  <= '0;
            rsp_q   <= '0;
        end else begin
            if (take) begin
                a_q     <= sel_a;
                u_q     <= sel_u;
                last_q  <= sel_last;
                owner_q <= sel_idx;
            end
            if (take && state_q == IDLE)
                ptr_q <= rr_next(rr_idx, NUM_REQ);
            if (state_q == ISSUE) lat_q <= 3'd1;
            else                  lat_q <= lat_q + 3'd1;
            if (state_q == RESP || take)
                idle_q <= '0;
            else if (state_q == HOLD)
                idle_q <= idle_q + 8'd1;
            if (capture) rsp_q <= i_shop_a;
        end
    end

    assign o_a     = a_q;
    assign o_u     = u_q;
    assign o_rsp_a = rsp_q;
    assign o_owner = owner_q;

endmodule

// File: tb/tb_shop_port_arbiter.sv
// Bench for shop_port_arbiter: grant-order table, session corner
// sequences and random multi-terminal traffic against a session model.
`timescale 1ns/1ps
module tb_shop_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 56;
    localparam int UW = 4;
    localparam int RW = 72;
    localparam int RL = 2;
    localparam int TO = 255;
    localparam logic [RW-1:0] CMD72 = {40'd0, "Cmd?"};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  valid = '0;
    logic [N-1:0]  last = '0;
    logic [N*AW-1:0] req_a = '0;
    logic [N*UW-1:0] req_u = '0;
    logic [N-1:0]  ready, rsp_valid;
    logic          rdy, timeout;
    logic [UW-1:0] o_u;
    logic [AW-1:0] o_a;
    logic [RW-1:0] shop_a = '0;
    logic [RW-1:0] rsp_a;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    shop_port_arbiter #(
        .NUM_REQ(N), .I_A_NUM_BITS(AW), .I_U_NUM_BITS(UW),
        .O_A_NUM_BITS(RW), .RESP_LAT(RL), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(valid), .i_req_last(last),
        .i_req_a(req_a), .i_req_u(req_u),
        .o_req_ready(ready), .o_rdy(rdy),
        .o_u(o_u), .o_a(o_a), .i_shop_a(shop_a),
        .o_rsp_valid(rsp_valid), .o_rsp_a(rsp_a),
        .o_timeout(timeout), .o_owner(owner)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [UW-1:0] u;
        logic          last;
        logic [1:0]    o;
    } word_t;

    typedef struct {
        logic [2:0]      mask;
        int              n;
        logic [2:0][1:0] ord;
    } vec_t;

    word_t tq[N][$];
    word_t exp_q[$];
    word_t cur;
    int    cyc = 0, acc_cyc = -10, rsp_due = 0, to_due = -1;
    int    n_pass = 0, n_total = 0;
    bit    rsp_pend = 0, use_cmd = 0;
    logic [RW-1:0] rsp_val = '0, rsp_hold = '0;
    logic [N-1:0]  ready_s = '0;

    task automatic chk(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] want);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)",
                      name, act, want, cyc);
    endtask

    function automatic logic [RW-1:0] rnd72();
        return RW'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [AW-1:0] rnd56();
        return AW'({$urandom(), $urandom()});
    endfunction

    function automatic word_t mk(input int k, input logic [AW-1:0] a,
                                 input logic [UW-1:0] u, input logic l);
        word_t w;
        w.a = a; w.u = u; w.last = l; w.o = 2'(k);
        return w;
    endfunction

    function automatic bit busy();
        for (int k = 0; k < N; k++) if (tq[k].size() != 0) return 1;
        return 0;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            valid[k] = (tq[k].size() != 0);
            if (tq[k].size() != 0) begin
                req_a[k*AW +: AW] = tq[k][0].a;
                req_u[k*UW +: UW] = tq[k][0].u;
                last[k]           = tq[k][0].last;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({rdy, ready, rsp_valid, timeout} == '0, {tag, "_ctrl"},
            128'({rdy, ready, rsp_valid, timeout}), 128'(0));
        chk(o_a == '0 && o_u == '0, {tag, "_word"},
            128'({o_u, o_a}), 128'(0));
        chk(rsp_a == '0, {tag, "_rsp_a"}, 128'(rsp_a), 128'(0));
        chk(owner == '0, {tag, "_owner"}, 128'(owner), 128'(0));
    endtask

    task automatic clear_sb();
        for (int k = 0; k < N; k++) tq[k].delete();
        exp_q.delete();
        rsp_pend = 0;
        rsp_hold = '0;
        to_due   = -1;
        use_cmd  = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sb();
        valid = '1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("reset");
        valid = '0;
        rst_n = 1'b1;
    endtask

    // One clock: check at the falling edge, update stimulus after the rise.
    task automatic cycle();
        bit           due;
        logic [N-1:0] erv;
        @(negedge clk);
        due = rsp_pend && cyc == rsp_due;
        erv = due ? (N'(1) << cur.o) : '0;
        if (due) rsp_hold = rsp_val;
        chk(rsp_valid == erv && (!due || (o_a == cur.a && o_u == cur.u)),
            "rsp_valid", 128'(rsp_valid), 128'(erv));
        chk(rsp_a == rsp_hold, "rsp_a", 128'(rsp_a), 128'(rsp_hold));
        chk(timeout == (cyc == to_due), "timeout",
            128'(timeout), 128'(cyc == to_due));
        chk((ready & ~valid) == '0 && $onehot0(ready), "ready",
            128'(ready), 128'(valid));
        if (due) begin
            rsp_pend = 0;
            if (!cur.last && tq[cur.o].size() == 0) to_due = cyc + TO;
        end
        if (rdy) begin
            if (exp_q.size() == 0) begin
                chk(0, "extra_strobe", 128'(o_a), 128'(0));
            end else begin
                cur = exp_q.pop_front();
                chk(o_a == cur.a && o_u == cur.u && owner == cur.o &&
                    cyc == acc_cyc + 1 && !rsp_pend, "strobe",
                    128'({owner, o_u, o_a}), 128'({cur.o, cur.u, cur.a}));
                rsp_pend = 1;
                rsp_due  = cyc + RL + 1;
                rsp_val  = use_cmd ? CMD72 : rnd72();
            end
        end
        ready_s = ready;
        if (ready_s != '0) acc_cyc = cyc;
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < N; k++)
            if (ready_s[k] && tq[k].size() != 0) tq[k].delete(0);
        shop_a = (rsp_pend && cyc == rsp_due - 1) ? rsp_val : rnd72();
        drive();
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 || rsp_pend || to_due >= cyc || busy()) begin
            cycle();
            n++;
            if (n > budget) begin
                chk(0, "budget", 128'(n), 128'(budget));
                break;
            end
        end
        repeat (3) cycle();
    endtask

    initial begin
        vec_t  tbl[7];
        word_t w[N];
        word_t m[N][$];
        word_t wd;
        int    mptr, g, kk, len, ntx;
        bit    found;
        logic [2:0] mask;

        tbl = '{
            '{3'b111, 3, {2'd2, 2'd1, 2'd0}},
            '{3'b111, 3, {2'd2, 2'd1, 2'd0}},
            '{3'b110, 2, {2'd0, 2'd2, 2'd1}},
            '{3'b001, 1, {2'd0, 2'd0, 2'd0}},
            '{3'b101, 2, {2'd0, 2'd0, 2'd2}},
            '{3'b011, 2, {2'd0, 2'd0, 2'd1}},
            '{3'b100, 1, {2'd0, 2'd0, 2'd2}}
        };

        do_reset();

        // Single-word Login on terminal 0, shop answers "Cmd?".
        use_cmd = 1;
        wd = mk(0, {16'd0, "Login"}, 4'd1, 1'b1);
        tq[0].push_back(wd);
        exp_q.push_back(wd);
        drive();
        run(100);
        chk(rsp_a == CMD72, "cmd_hold", 128'(rsp_a), 128'(CMD72));
        use_cmd = 0;

        // Grant order table, pointer carried across rows.
        do_reset();
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < N; k++) begin
                if (tbl[r].mask[k]) begin
                    w[k] = mk(k, rnd56(), 4'($urandom_range(0, 15)), 1'b1);
                    tq[k].push_back(w[k]);
                end
            end
            for (int i = 0; i < tbl[r].n; i++)
                exp_q.push_back(w[tbl[r].ord[i]]);
            drive();
            run(200);
            chk(exp_q.size() == 0, "vec_order",
                128'(exp_q.size()), 128'(0));
        end

        // Three-word session on terminal 1 while terminal 2 waits.
        w[0] = mk(1, {16'd0, "Login"}, 4'd2, 1'b0);
        w[1] = mk(1, {32'd0, "Adm"}, 4'd2, 1'b0);
        w[2] = mk(1, {32'd0, "123"}, 4'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tq[1].push_back(w[i]);
            exp_q.push_back(w[i]);
        end
        wd = mk(2, {8'd0, "AddUsr"}, 4'd3, 1'b1);
        tq[2].push_back(wd);
        exp_q.push_back(wd);
        drive();
        run(300);

        // Abandoned session times out, then terminal 1 is served.
        wd = mk(0, {8'd0, "DelUsr"}, 4'd4, 1'b0);
        tq[0].push_back(wd);
        exp_q.push_back(wd);
        wd = mk(1, {16'd0, "Login"}, 4'd5, 1'b1);
        tq[1].push_back(wd);
        exp_q.push_back(wd);
        drive();
        run(1000);

        // Reset while waiting on the shop.
        wd = mk(0, rnd56(), 4'd6, 1'b1);
        tq[0].push_back(wd);
        exp_q.push_back(wd);
        drive();
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            cycle();
            g++;
        end
        chk(g < 50, "wait_strobe", 128'(g), 128'(50));
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        clear_sb();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (RL + 4) cycle();

        // Random sessions against a round-robin session model.
        do_reset();
        mptr = 0;
        for (int r = 0; r < 25; r++) begin
            mask = 3'($urandom_range(1, 7));
            for (int k = 0; k < N; k++) begin
                m[k].delete();
                if (mask[k]) begin
                    ntx = $urandom_range(1, 2);
                    for (int t = 0; t < ntx; t++) begin
                        len = $urandom_range(1, 3);
                        for (int j = 0; j < len; j++) begin
                            wd = mk(k, rnd56(), 4'($urandom_range(0, 15)),
                                    j == len - 1);
                            tq[k].push_back(wd);
                            m[k].push_back(wd);
                        end
                    end
                end
            end
            found = 1;
            while (found) begin
                found = 0;
                for (int i = 0; i < N && !found; i++) begin
                    kk = (mptr + i) % N;
                    if (m[kk].size() != 0) begin
                        found = 1;
                        do begin
                            wd = m[kk].pop_front();
                            exp_q.push_back(wd);
                        end while (!wd.last);
                        mptr = (kk + 1) % N;
                    end
                end
            end
            drive();
            run(2000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
